// File: rtl/alu_mul_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mul_sequencer_if
//  Purpose  : Bundle of the multiply request/response signals and the shared
//             ALU drive/return signals used by alu_mul_sequencer.
//  Modports : slave  - the sequencer (consumes start/operands/ALU result,
//                      drives busy/done/product/ALU operands and control)
//             master - the execute-stage side (requester plus the ALU)
//  Signals  : start_i, multiplicand_i, multiplier_i  request
//             busy_o, done_o, product_o               status / result
//             alu_src1_o, alu_src2_o, alu_ctrl_o      ALU drive
//             alu_result_i, alu_cout_i                ALU return
//  Revision : 1.0  initial release
// ============================================================================
interface alu_mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic [WIDTH-1:0]   multiplicand_i;
  logic [WIDTH-1:0]   multiplier_i;
  logic               busy_o;
  logic               done_o;
  logic [2*WIDTH-1:0] product_o;
  logic [WIDTH-1:0]   alu_src1_o;
  logic [WIDTH-1:0]   alu_src2_o;
  logic [3:0]         alu_ctrl_o;
  logic [WIDTH-1:0]   alu_result_i;
  logic               alu_cout_i;

  modport slave (
    input  start_i, multiplicand_i, multiplier_i, alu_result_i, alu_cout_i,
    output busy_o, done_o, product_o, alu_src1_o, alu_src2_o, alu_ctrl_o
  );

  modport master (
    output start_i, multiplicand_i, multiplier_i, alu_result_i, alu_cout_i,
    input  busy_o, done_o, product_o, alu_src1_o, alu_src2_o, alu_ctrl_o
  );
endinterface
`default_nettype wire

// File: rtl/alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mul_sequencer
//  Purpose  : Unsigned WIDTHxWIDTH -> 2*WIDTH multiply performed as WIDTH
//             shift-add steps on the shared ripple ALU. The ALU is owned only
//             while busy_o is high; otherwise its operands/control are zero.
//  Ports    : clk_i  - clock, rising edge
//             rst_i  - asynchronous active-high reset
//             bus    - alu_mul_sequencer_if.slave (request, status, product,
//                      ALU drive and ALU return)
//  Notes    : Only WIDTH = 32 is supported (step counter is 6 bits and the
//             width must match the ALU).
//  Revision : 1.0  initial release
// ============================================================================
module alu_mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  alu_mul_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [5:0] c_LAST_STEP = 6'(WIDTH - 1);
  localparam logic [3:0] c_CTRL_ADD  = 4'b0010;   // add, no inversion, cin=0
  localparam logic [3:0] c_CTRL_IDLE = 4'b0000;

  state_t           r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [5:0]       r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [3:0]       r_alu_ctrl;

  logic             w_accept;
  logic             w_carry;
  logic [WIDTH-1:0] w_sum;

  // A new request is only looked at when not running; start_i during RUN
  // is dropped, not queued.
  always_comb begin
    w_accept = bus.start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
  end

  // Partial-sum select. The ALU is combinational on hi + mcand, so its sum
  // is consumed in the same cycle; when lo[0] is clear hi passes through
  // with a zero carry.
  always_comb begin
    w_carry = 1'b0;
    w_sum   = r_hi;
    if (r_lo[0]) begin
      w_carry = bus.alu_cout_i;
      w_sum   = bus.alu_result_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_mcand    <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_alu_ctrl <= c_CTRL_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_mcand    <= bus.multiplicand_i;
            r_hi       <= '0;
            r_lo       <= bus.multiplier_i;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_alu_ctrl <= c_CTRL_ADD;
            r_state    <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_RUN: begin
          // {hi,lo} <= {carry, sum, lo[W-1:1]} : 65-bit shift right by one.
          r_hi  <= {w_carry, w_sum[WIDTH-1:1]};
          r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == c_LAST_STEP) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_alu_ctrl <= c_CTRL_IDLE;
            r_state    <= S_DONE;
          end
        end

        default: begin
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_alu_ctrl <= c_CTRL_IDLE;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  // Operand drive is gated by the registered busy flag so the ALU mux is
  // released (all zero) whenever the sequencer does not own it.
  assign bus.busy_o     = r_busy;
  assign bus.done_o     = r_done;
  assign bus.product_o  = {r_hi, r_lo};
  assign bus.alu_src1_o = r_busy ? r_hi    : '0;
  assign bus.alu_src2_o = r_busy ? r_mcand : '0;
  assign bus.alu_ctrl_o = r_alu_ctrl;

endmodule
`default_nettype wire
